// File: rtl/trng_pkg.sv
// Shared types and defaults for the serial TRNG source: debiaser state
// encoding and the default buffer depth and repetition-test cutoff.
package trng_pkg;

  localparam int unsigned TRNG_DEPTH_DEF      = 32;
  localparam int unsigned TRNG_RCT_CUTOFF_DEF = 16;

  typedef enum logic {
    DB_EMPTY      = 1'b0,
    DB_HAVE_FIRST = 1'b1
  } db_state_t;

endpackage

// File: rtl/trng_vn_debias.sv
// Von Neumann debiaser: pairs raw bits, emits the first bit of 01/10 pairs
// one cycle after the completing raw bit, and discards 00/11 pairs.
module trng_vn_debias
  import trng_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic raw_valid,
  input  logic raw_bit,
  input  logic flush,
  output logic out_valid,
  output logic out_bit
);

  db_state_t state;
  logic      first_bit;

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      state     <= DB_EMPTY;
      first_bit <= 1'b0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (raw_valid) begin
        case (state)
          DB_EMPTY: begin
            first_bit <= raw_bit;
            state     <= DB_HAVE_FIRST;
          end
          DB_HAVE_FIRST: begin
            state <= DB_EMPTY;
            if (first_bit != raw_bit) begin
              out_valid <= 1'b1;
              out_bit   <= first_bit;
            end
          end
          default: state <= DB_EMPTY;
        endcase
      end
    end
  end

endmodule

// File: rtl/trng_serial_src.sv
// Serial TRNG source: repetition-count health test on raw entropy, Von Neumann
// debiasing, and a bit FIFO popped one bit per cycle by the consumer.
module trng_serial_src
  import trng_pkg::*;
#(
  parameter int unsigned DEPTH      = TRNG_DEPTH_DEF,
  parameter int unsigned RCT_CUTOFF = TRNG_RCT_CUTOFF_DEF
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     raw_valid,
  input  logic                     raw_bit,
  input  logic                     trng_req,
  output logic                     trng_bit,
  output logic                     trng_avail,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     health_fail,
  output logic                     underflow,
  input  logic                     clear_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(RCT_CUTOFF + 1);

  logic [CW-1:0]    rep_cnt;
  logic             prev_bit;
  logic             trip;
  logic             fail_now;
  logic             deb_flush;
  logic             deb_valid;
  logic             deb_bit;
  logic             push;
  logic             pop;
  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // The trip is acted on in the same cycle health_fail is registered, so the
  // buffer is already empty when the flag becomes visible.
  assign trip      = (rep_cnt == CW'(RCT_CUTOFF));
  assign fail_now  = (health_fail | trip) & ~clear_err;
  assign deb_flush = fail_now | clear_err;

  assign push = deb_valid && !fail_now && (level < LW'(DEPTH));
  assign pop  = trng_req && (level != '0);

  assign trng_bit   = (level != '0) ? mem[rd_ptr] : 1'b0;
  assign trng_avail = (level != '0) && !health_fail;

  trng_vn_debias u_debias (
    .clk       (clk),
    .resetn    (resetn),
    .raw_valid (raw_valid),
    .raw_bit   (raw_bit),
    .flush     (deb_flush),
    .out_valid (deb_valid),
    .out_bit   (deb_bit)
  );

  always_ff @(posedge clk) begin
    if (!resetn || clear_err) begin
      rep_cnt  <= '0;
      prev_bit <= 1'b0;
    end else if (raw_valid) begin
      prev_bit <= raw_bit;
      if (rep_cnt == '0 || raw_bit != prev_bit) begin
        rep_cnt <= CW'(1);
      end else if (rep_cnt < CW'(RCT_CUTOFF)) begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      health_fail <= 1'b0;
      underflow   <= 1'b0;
    end else if (clear_err) begin
      health_fail <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      if (trip) health_fail <= 1'b1;
      if (trng_req && level == '0) underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || fail_now) begin
      level  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !push) begin
        level <= level - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= deb_bit;
  end

endmodule

// File: tb/tb_trng_serial_src.sv
// Scoreboard bench for trng_serial_src: directed raw-bit sequences queue the
// expected debiased bits; a negedge monitor checks each popped bit.
module tb_trng_serial_src;

  localparam int DEPTH = 32;
  localparam int RCT   = 16;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic raw_valid = 1'b0;
  logic raw_bit = 1'b0;
  logic trng_req = 1'b0;
  logic clear_err = 1'b0;
  logic trng_bit;
  logic trng_avail;
  logic health_fail;
  logic underflow;
  logic [$clog2(DEPTH):0] level;

  int   n_tests = 0;
  int   n_fail  = 0;
  bit   sb_q[$];
  bit   exp_b;

  always #5 clk = ~clk;

  trng_serial_src #(.DEPTH(DEPTH), .RCT_CUTOFF(RCT)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .raw_valid   (raw_valid),
    .raw_bit     (raw_bit),
    .trng_req    (trng_req),
    .trng_bit    (trng_bit),
    .trng_avail  (trng_avail),
    .level       (level),
    .health_fail (health_fail),
    .underflow   (underflow),
    .clear_err   (clear_err)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic raw(input logic b);
    raw_valid = 1'b1;
    raw_bit   = b;
    tick();
    raw_valid = 1'b0;
  endtask

  task automatic pair(input logic a, input logic b, input bit track);
    raw(a);
    raw(b);
    if (track && a != b) sb_q.push_back(a);
  endtask

  task automatic pop_n(input int n);
    trng_req = 1'b1;
    tick(n);
    trng_req = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_level"}, int'(level), 0);
    check({tag, "_bit"}, int'(trng_bit), 0);
    check({tag, "_avail"}, int'(trng_avail), 0);
    check({tag, "_hf"}, int'(health_fail), 0);
    check({tag, "_uf"}, int'(underflow), 0);
  endtask

  always @(negedge clk) begin
    if (resetn && trng_req && trng_avail) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got pop of %0d expected none", trng_bit);
      end else begin
        exp_b = sb_q.pop_front();
        check("sb_bit", int'(trng_bit), int'(exp_b));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pat;
    logic [9:0]  pat2;
    pat  = 32'hA5C3_96E1;
    pat2 = 10'b11_0010_1011;

    // reset state
    tick(2);
    check_idle("reset");
    resetn = 1'b1;
    tick();

    // pairs 01,10,00,11,10 -> 0,1,1
    pair(1'b0, 1'b1, 1'b1);
    pair(1'b1, 1'b0, 1'b1);
    pair(1'b0, 1'b0, 1'b1);
    pair(1'b1, 1'b1, 1'b1);
    pair(1'b1, 1'b0, 1'b1);
    tick(2);
    check("basic_level", int'(level), 3);
    check("basic_avail", int'(trng_avail), 1);
    pop_n(3);
    check("basic_drain_level", int'(level), 0);
    check("basic_drain_bit", int'(trng_bit), 0);

    // underflow
    pop_n(2);
    check("uf_set", int'(underflow), 1);
    check("uf_bit", int'(trng_bit), 0);
    check("uf_level", int'(level), 0);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("uf_clear", int'(underflow), 0);

    // repetition test trip flushes buffered bits
    pair(1'b1, 1'b0, 1'b0);
    pair(1'b1, 1'b0, 1'b0);
    tick(2);
    check("rct_prefill", int'(level), 2);
    for (int i = 0; i < RCT; i++) raw(1'b1);
    check("rct_not_yet", int'(health_fail), 0);
    tick();
    check("rct_hf", int'(health_fail), 1);
    check("rct_level", int'(level), 0);
    check("rct_avail", int'(trng_avail), 0);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("rct_clear", int'(health_fail), 0);
    // a run of 15 after clear must not trip: counter restarted
    for (int i = 0; i < 14; i++) raw(1'b1);
    pair(1'b1, 1'b0, 1'b1);
    tick(2);
    check("rct_restart_hf", int'(health_fail), 0);
    check("rct_restart_level", int'(level), 1);
    pop_n(1);

    // fill to DEPTH, extra pairs dropped
    for (int i = 0; i < DEPTH; i++) pair(pat[i], ~pat[i], 1'b1);
    for (int i = 0; i < 5; i++) pair(1'b0, 1'b1, 1'b0);
    tick(2);
    check("full_level", int'(level), DEPTH);
    pop_n(DEPTH);
    check("full_drain", int'(level), 0);

    // push and pop in the same cycle at level 1
    pair(1'b1, 1'b0, 1'b1);
    tick(2);
    check("pp_pre_level", int'(level), 1);
    raw(1'b0);
    raw_valid = 1'b1;
    raw_bit   = 1'b1;
    tick();
    raw_valid = 1'b0;
    sb_q.push_back(1'b0);
    trng_req = 1'b1;
    tick();
    trng_req = 1'b0;
    check("pp_level", int'(level), 1);
    check("pp_head", int'(trng_bit), 0);
    pop_n(1);

    // reset while HAVE_FIRST with level 10
    for (int i = 0; i < 10; i++) pair(pat2[i], ~pat2[i], 1'b0);
    tick(2);
    check("rst_pre_level", int'(level), 10);
    raw(1'b1);
    resetn = 1'b0;
    tick();
    check_idle("midrst");
    resetn = 1'b1;
    raw(1'b0);
    tick(3);
    check("rst_single_nopush", int'(level), 0);
    raw(1'b1);
    sb_q.push_back(1'b0);
    tick(2);
    check("rst_pair_level", int'(level), 1);
    pop_n(1);
    tick(2);

    check("sb_drain", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/trng_serial_src.md
TRNG_SERIAL_SRC -- requirements
Module: trng_serial_src

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning bit-buffer capacity in bits (power of two, 8..64).
REQ-002 SHALL have parameter RCT_CUTOFF, default 16, meaning the count of consecutive identical raw bits that trips the health test.
REQ-003 SHALL have port clk, input, 1, system clock.
REQ-004 SHALL have port resetn, input, 1: reset resetn, synchronous, active-low; clock clk.
REQ-005 SHALL have port raw_valid, input, 1, raw entropy bit strobe.
REQ-006 SHALL have port raw_bit, input, 1, raw entropy sample, qualified by raw_valid.
REQ-007 SHALL have port trng_req, input, 1, consumer pop request, one bit per cycle while high.
REQ-008 SHALL have port trng_bit, output, 1, head-of-buffer bit presented to the consumer.
REQ-009 SHALL have port trng_avail, output, 1, high when level > 0 and health_fail is low.
REQ-010 SHALL have port level, output, $clog2(DEPTH)+1, buffered bit count.
REQ-011 SHALL have port health_fail, output, 1, sticky repetition-test failure.
REQ-012 SHALL have port underflow, output, 1, sticky pop-while-empty flag.
REQ-013 SHALL have port clear_err, input, 1, single-cycle clear of sticky flags.

Function
REQ-014 Debiaser SHALL be a two-state FSM, EMPTY/HAVE_FIRST: on raw_valid in EMPTY it stores raw_bit and moves to HAVE_FIRST; on raw_valid in HAVE_FIRST it returns to EMPTY.
REQ-015 On the second bit of a pair, debiaser SHALL emit the first bit for pairs 01 and 10, and emit nothing for pairs 00 and 11.
REQ-016 Debiaser output SHALL reach the buffer one cycle after the raw_valid that completes the pair.
REQ-017 Repetition counter SHALL reset to 1 when raw_bit differs from the previous raw bit, and increment (saturating at RCT_CUTOFF) when it matches, on every raw_valid.
REQ-018 health_fail SHALL set in the cycle after the counter reaches RCT_CUTOFF.
REQ-019 While health_fail is high, buffer SHALL be flushed to level 0, pushes SHALL be blocked, and the debiaser SHALL be held in EMPTY.
REQ-020 Buffer SHALL be FIFO-ordered; push occurs when a debiased bit arrives and level < DEPTH.
REQ-021 A debiased bit arriving when level == DEPTH SHALL be dropped silently.
REQ-022 Pop SHALL occur on each rising edge where trng_req is high and level > 0.
REQ-023 trng_bit SHALL equal the oldest buffered bit when level > 0, and SHALL be 0 when level == 0.
REQ-024 Simultaneous push and pop SHALL leave level unchanged and append the new bit behind the remaining bits; at level == 0 the new bit becomes the head next cycle.
REQ-025 trng_req high with level == 0 SHALL set underflow and SHALL leave level at 0.
REQ-026 clear_err SHALL clear health_fail and underflow, reset the repetition counter to 0, and return the debiaser to EMPTY; in that cycle clear takes priority over set.
REQ-027 All outputs SHALL be registered or driven from registered state only, with no combinational path from trng_req to trng_bit.

Reset
REQ-028 While resetn is low at a clock edge: level=0, trng_bit=0, trng_avail=0, health_fail=0, underflow=0, debiaser in EMPTY, repetition counter at 0.
REQ-029 Reset SHALL override all inputs, including assertion mid-pair and mid-pop.
REQ-030 Buffer storage contents need not be cleared by reset.

Structure
REQ-031 Shared package trng_pkg SHALL hold the debiaser state enum and the default DEPTH and RCT_CUTOFF constants.
REQ-032 The debiaser SHALL be a sub-module, trng_vn_debias, with ports raw_valid, raw_bit, flush, out_valid and out_bit.

Verification
REQ-033 Raw pairs 01,10,00,11,10 with trng_req low -> level=3, then trng_req high for 3 cycles yields trng_bit 0,1,1, then level=0.
REQ-034 16 consecutive raw 1s -> health_fail=1 next cycle, level=0, trng_avail=0; then clear_err -> health_fail=0 and counter restarts.
REQ-035 Fill to DEPTH=32, then 5 more valid pairs -> level stays 32 and the first 32 bits pop in order unchanged.
REQ-036 level=0 with trng_req high for 2 cycles -> underflow=1, trng_bit=0, level=0; clear_err -> underflow=0.
REQ-037 level=1 with a pair completing while trng_req is held high -> level stays 1, head equals the new bit.
REQ-038 resetn low for one cycle while HAVE_FIRST and level=10 -> all REQ-028 values; the next single raw bit produces no push.
